ula_multibyte_ctrl: RTL and testbench

Sequencer that runs NUM_BYTES-wide operations on a single ula_8_bits instance, one byte per cycle, LSB first.
- Chains the ALU carry-out into the next byte's carry-in.
- Accumulates result bytes and per-byte equality.
- Returns the full-width result and status flags through a valid/ready output handshake.
- Sits between the datapath register file and the existing 8-bit ULA.

---
 rtl/ula_ctrl_pkg.sv | 42 ++++
 rtl/ula_8_bits.sv | 58 +++++
 rtl/ula_multibyte_ctrl.sv | 135 +++++++++++++
 tb/tb_ula_multibyte_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_ctrl_pkg.sv
// Shared types and ALU select encodings for the multibyte ULA sequencer.
package ula_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_CMP  = 3'b101,
    OP_RSV6 = 3'b110,
    OP_RSV7 = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] S_ADD  = 4'b1001;
  localparam logic [3:0] S_SUB  = 4'b0110;
  localparam logic [3:0] S_AND  = 4'b1000;
  localparam logic [3:0] S_OR   = 4'b1110;
  localparam logic [3:0] S_XOR  = 4'b0110;
  localparam logic [3:0] S_XNOR = 4'b1001;
  localparam logic [3:0] S_ZERO = 4'b0011;

  // Returns {m, s}; reserved opcodes force the ALU to constant zero.
  function automatic logic [4:0] op_to_alu(op_e op);
    case (op)
      OP_ADD:  return {1'b0, S_ADD};
      OP_SUB:  return {1'b0, S_SUB};
      OP_AND:  return {1'b1, S_AND};
      OP_OR:   return {1'b1, S_OR};
      OP_XOR:  return {1'b1, S_XOR};
      OP_CMP:  return {1'b1, S_XNOR};
      default: return {1'b1, S_ZERO};
    endcase
  endfunction

endpackage

// File: rtl/ula_8_bits.sv
// 8-bit ULA: arithmetic (m=0) with active-high carry, logic functions (m=1).
module ula_8_bits (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       c_in,
  output logic [7:0] f,
  output logic       c_out,
  output logic       overflow,
  output logic       a_eq_b,
  output logic       p,
  output logic       g
);

  logic [7:0] x;
  logic [8:0] sum;
  logic [8:0] gsum;

  always_comb begin
    x        = 8'h00;
    sum      = 9'h000;
    gsum     = 9'h000;
    f        = 8'h00;
    c_out    = 1'b0;
    overflow = 1'b0;
    case (s)
      4'b1001: x = b;
      4'b0110: x = ~b;
      default: x = 8'h00;
    endcase
    sum  = {1'b0, a} + {1'b0, x} + 9'(c_in);
    gsum = {1'b0, a} + {1'b0, x};
    if (!m) begin
      f        = sum[7:0];
      c_out    = sum[8];
      overflow = (a[7] == x[7]) && (sum[7] != a[7]);
    end else begin
      case (s)
        4'b0000: f = ~a;
        4'b0001: f = ~(a | b);
        4'b0011: f = 8'h00;
        4'b0110: f = a ^ b;
        4'b1000: f = a & b;
        4'b1001: f = ~(a ^ b);
        4'b1010: f = b;
        4'b1110: f = a | b;
        4'b1111: f = a;
        default: f = ~a;
      endcase
    end
  end

  assign a_eq_b = &f;
  assign p      = &(a ^ x);
  assign g      = gsum[8];

endmodule

// File: rtl/ula_multibyte_ctrl.sv
// Runs NUM_BYTES-wide operations byte-serially (LSB first) on one ula_8_bits,
// chaining carry and returning result plus flags through a valid/ready handshake.
module ula_multibyte_ctrl
  import ula_ctrl_pkg::*;
#(
  parameter int unsigned NUM_BYTES = 4,
  localparam int unsigned W = 8 * NUM_BYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         out_carry,
  output logic         out_overflow,
  output logic         out_zero,
  output logic         out_eq,
  output logic         out_err,
  output logic         busy
);

  localparam int unsigned IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  typedef logic [NUM_BYTES-1:0][7:0] word_t;

  state_e     state_q, state_d;
  word_t      a_q, b_q, res_q, res_next;
  op_e        op_q;
  logic [IDX_W-1:0] idx_q;
  logic       carry_q, eq_q;

  logic [4:0] alu_ms;
  logic [7:0] alu_f;
  logic       alu_c_out, alu_ovf, alu_eq;
  logic       unused_p, unused_g;
  logic       last_byte, is_arith, is_rsv;

  assign alu_ms    = op_to_alu(op_q);
  assign last_byte = (idx_q == IDX_W'(NUM_BYTES - 1));
  assign is_arith  = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign is_rsv    = (op_q == OP_RSV6) || (op_q == OP_RSV7);

  ula_8_bits u_alu (
    .a        (a_q[idx_q]),
    .b        (b_q[idx_q]),
    .s        (alu_ms[3:0]),
    .m        (alu_ms[4]),
    .c_in     (carry_q),
    .f        (alu_f),
    .c_out    (alu_c_out),
    .overflow (alu_ovf),
    .a_eq_b   (alu_eq),
    .p        (unused_p),
    .g        (unused_g)
  );

  // Accumulated result with the current byte merged in.
  always_comb begin
    res_next        = res_q;
    res_next[idx_q] = alu_f;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = EXEC;
      EXEC:    if (last_byte) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      op_q         <= OP_ADD;
      idx_q        <= '0;
      carry_q      <= 1'b0;
      eq_q         <= 1'b0;
      in_ready     <= 1'b1;
      busy         <= 1'b0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_carry    <= 1'b0;
      out_overflow <= 1'b0;
      out_zero     <= 1'b0;
      out_eq       <= 1'b0;
      out_err      <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
      out_valid <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            op_q    <= op_e'(in_op);
            idx_q   <= '0;
            carry_q <= (op_e'(in_op) == OP_SUB);
            eq_q    <= 1'b1;
            res_q   <= '0;
          end
        end
        EXEC: begin
          res_q   <= res_next;
          carry_q <= alu_c_out;
          eq_q    <= eq_q & alu_eq;
          if (last_byte) begin
            // Outputs update only on completion so partial bytes never show.
            out_result   <= res_next;
            out_carry    <= is_arith & alu_c_out;
            out_overflow <= is_arith & alu_ovf;
            out_zero     <= (res_next == '0);
            out_eq       <= (op_q == OP_CMP) & eq_q & alu_eq;
            out_err      <= is_rsv;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_multibyte_ctrl.sv
// Scoreboard bench for ula_multibyte_ctrl with NUM_BYTES = 4.
module tb_ula_multibyte_ctrl;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  typedef struct packed {
    logic [W-1:0] result;
    logic         carry;
    logic         ovf;
    logic         zero;
    logic         eq;
    logic         err;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a, in_b, out_result;
  logic         out_carry, out_overflow, out_zero, out_eq, out_err, busy;

  int   nvec = 0;
  int   nerr = 0;
  res_t sb[$];

  ula_multibyte_ctrl #(.NUM_BYTES(NB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_a         (in_a),
    .in_b         (in_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_carry    (out_carry),
    .out_overflow (out_overflow),
    .out_zero     (out_zero),
    .out_eq       (out_eq),
    .out_err      (out_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t     r;
    logic [W:0] s;
    r = '0;
    s = '0;
    case (op)
      3'b000: begin
        s = {1'b0, a} + {1'b0, b};
        r.result = s[W-1:0];
        r.carry  = s[W];
        r.ovf    = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      end
      3'b001: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r.result = s[W-1:0];
        r.carry  = s[W];
        r.ovf    = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
      end
      3'b010: r.result = a & b;
      3'b011: r.result = a | b;
      3'b100: r.result = a ^ b;
      3'b101: begin
        r.result = ~(a ^ b);
        r.eq     = (a == b);
      end
      default: r.err = 1'b1;
    endcase
    r.zero = (r.result == '0);
    return r;
  endfunction

  function automatic res_t sample();
    res_t r;
    r.result = out_result;
    r.carry  = out_carry;
    r.ovf    = out_overflow;
    r.zero   = out_zero;
    r.eq     = out_eq;
    r.err    = out_err;
    return r;
  endfunction

  // Issue one request from a negedge, wait (bounded) for out_valid, leave DUT in DONE.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output res_t got, output int lat, output logic busy_all);
    sb.push_back(model(op, a, b));
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    busy_all = 1'b1;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy !== 1'b1) busy_all = 1'b0;
      if (out_valid === 1'b1) break;
    end
    @(negedge clk);
    if (out_valid !== 1'b1) begin
      nvec++; nerr++;
      $display("FAIL timeout op=%b: out_valid=%b after %0d cycles, required 1", op, out_valid, lat);
    end
    got = sample();
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [W+7:0] got_v;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_op = 3'b000; in_a = '0; in_b = '0;
    #12;
    got_v = {in_ready, out_valid, busy, out_carry, out_overflow, out_zero, out_eq, out_err, out_result};
    nvec++;
    if (got_v !== {1'b1, 7'b0, 32'h0}) begin
      nerr++;
      $display("FAIL reset_state: got %h, required %h", got_v, {1'b1, 7'b0, 32'h0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    res_t got, exp; int lat; logic ba;
    run_op(3'b000, 32'h000000FF, 32'h00000001, got, lat, ba);
    exp = sb.pop_front();
    nvec++; if (got !== exp) begin nerr++; $display("FAIL add_ff_1: got %h, required %h", got, exp); end
    nvec++; if (lat !== NB) begin nerr++; $display("FAIL add_latency: got %0d, required %0d", lat, NB); end
    nvec++; if (ba !== 1'b1) begin nerr++; $display("FAIL add_busy: got %b, required 1", ba); end
    finish_op();
    nvec++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      nerr++; $display("FAIL add_handshake: got %b, required 010", {out_valid, in_ready, busy});
    end
    run_op(3'b000, 32'h7FFFFFFF, 32'h00000001, got, lat, ba);
    exp = sb.pop_front();
    nvec++; if (got !== exp) begin nerr++; $display("FAIL add_ovf: got %h, required %h", got, exp); end
    finish_op();
    run_op(3'b000, 32'hFFFFFFFF, 32'h00000001, got, lat, ba);
    exp = sb.pop_front();
    nvec++; if (got !== exp) begin nerr++; $display("FAIL add_carry: got %h, required %h", got, exp); end
    finish_op();
  endtask

  task automatic test_sub();
    res_t got, exp; int lat; logic ba;
    run_op(3'b001, 32'h00000000, 32'h00000001, got, lat, ba);
    exp = sb.pop_front();
    nvec++; if (got !== exp) begin nerr++; $display("FAIL sub_borrow: got %h, required %h", got, exp); end
    finish_op();
    run_op(3'b001, 32'h80000000, 32'h00000001, got, lat, ba);
    exp = sb.pop_front();
    nvec++; if (got !== exp) begin nerr++; $display("FAIL sub_ovf: got %h, required %h", got, exp); end
    finish_op();
  endtask

  task automatic test_logic();
    res_t got, exp; int lat; logic ba;
    for (int k = 2; k <= 4; k++) begin
      run_op(3'(k), 32'hAAAAAAAA, 32'h55555555, got, lat, ba);
      exp = sb.pop_front();
      nvec++;
      if (got !== exp) begin nerr++; $display("FAIL logic_op%0d: got %h, required %h", k, got, exp); end
      finish_op();
    end
  endtask

  task automatic test_cmp();
    res_t got, exp; int lat; logic ba;
    run_op(3'b101, 32'h12345678, 32'h12345678, got, lat, ba);
    exp = sb.pop_front();
    nvec++; if (got !== exp) begin nerr++; $display("FAIL cmp_equal: got %h, required %h", got, exp); end
    finish_op();
    run_op(3'b101, 32'h12345678, 32'h12345679, got, lat, ba);
    exp = sb.pop_front();
    nvec++; if (got !== exp) begin nerr++; $display("FAIL cmp_differ: got %h, required %h", got, exp); end
    finish_op();
    run_op(3'b110, 32'hDEADBEEF, 32'h01234567, got, lat, ba);
    exp = sb.pop_front();
    nvec++; if (got !== exp) begin nerr++; $display("FAIL reserved_op: got %h, required %h", got, exp); end
    finish_op();
  endtask

  task automatic test_backpressure();
    res_t got, exp; int lat; logic ba;
    run_op(3'b100, 32'h0F0F1234, 32'hFF00AA55, got, lat, ba);
    exp = sb.pop_front();
    for (int c = 0; c < 5; c++) begin
      in_op = 3'b000; in_a = 32'h1; in_b = 32'h1; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      got = sample();
      nvec++;
      if ({got, out_valid, in_ready} !== {exp, 2'b10}) begin
        nerr++;
        $display("FAIL hold_cycle%0d: got %h/%b%b, required %h/10", c, got, out_valid, in_ready, exp);
      end
    end
    in_valid = 1'b0;
    finish_op();
    repeat (3) @(negedge clk);
    nvec++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      nerr++; $display("FAIL dropped_request: got %b, required 001", {out_valid, busy, in_ready});
    end
  endtask

  task automatic test_reset_mid_exec();
    res_t got, exp; int lat; logic ba;
    logic [W+7:0] got_v;
    run_op(3'b000, 32'hFFFFFFFF, 32'h00000001, got, lat, ba);
    exp = sb.pop_front();
    nvec++; if (got !== exp) begin nerr++; $display("FAIL pre_reset_add: got %h, required %h", got, exp); end
    finish_op();
    in_op = 3'b000; in_a = 32'h11111111; in_b = 32'h22222222; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    got_v = {in_ready, out_valid, busy, out_carry, out_overflow, out_zero, out_eq, out_err, out_result};
    nvec++;
    if (got_v !== {1'b1, 7'b0, 32'h0}) begin
      nerr++; $display("FAIL reset_mid_exec: got %h, required %h", got_v, {1'b1, 7'b0, 32'h0});
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(3'b000, 32'd3, 32'd5, got, lat, ba);
    exp = sb.pop_front();
    nvec++; if (got !== exp) begin nerr++; $display("FAIL post_reset_add: got %h, required %h", got, exp); end
    finish_op();
  endtask

  task automatic test_back_to_back();
    res_t got, exp; int lat; logic ba;
    logic [2:0] op;
    for (int k = 0; k < 8; k++) begin
      op = 3'($urandom_range(0, 5));
      run_op(op, $urandom, $urandom, got, lat, ba);
      exp = sb.pop_front();
      nvec++;
      if ({got, 8'(lat)} !== {exp, 8'(NB)}) begin
        nerr++; $display("FAIL b2b_%0d op=%b: got %h lat %0d, required %h lat %0d", k, op, got, lat, exp, NB);
      end
      finish_op();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_cmp();
    test_backpressure();
    test_reset_mid_exec();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
